// File: rtl/w6debug_host.sv
// Host (initiator) end of the w6debug serial link: turns byte write/read requests
// into 8-bit MSB-first transfers clocked by a divided link clock.
module w6debug_host #(
  parameter int CLK_DIV = 32,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       rx_req,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       dev_rts,
  output logic       link_clk,
  output logic       link_dir,
  output logic       link_dout,
  input  logic       link_din,
  input  logic       link_cts,
  input  logic       link_rts
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  // Bit 0 = link_din, bit 1 = link_cts, bit 2 = link_rts.
  logic [2:0] async_in;
  logic [2:0] meta_reg;
  logic [2:0] sync_reg;
  logic       din_s;
  logic       cts_s;

  assign async_in = {link_rts, link_cts, link_din};
  assign din_s    = sync_reg[0];
  assign cts_s    = sync_reg[1];
  assign dev_rts  = sync_reg[2];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          meta_reg[gi] <= 1'b0;
          sync_reg[gi] <= 1'b0;
        end else begin
          meta_reg[gi] <= async_in[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       rx_shift_reg;
  logic             op_wr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      rx_shift_reg <= '0;
      op_wr_reg    <= 1'b0;
      tx_ready     <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      busy         <= 1'b0;
      link_clk     <= 1'b0;
      link_dir     <= 1'b1;
      link_dout    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shift_reg   <= tx_data;
            op_wr_reg   <= 1'b1;
            link_dir    <= 1'b1;
            link_dout   <= tx_data[7];
            bit_cnt_reg <= '0;
            cnt_reg     <= RELOAD;
            state_reg   <= LOW;
            busy        <= 1'b1;
            tx_ready    <= 1'b0;
          end else if (rx_req) begin
            op_wr_reg   <= 1'b0;
            link_dir    <= 1'b0;
            bit_cnt_reg <= '0;
            cnt_reg     <= RELOAD;
            state_reg   <= LOW;
            busy        <= 1'b1;
            tx_ready    <= 1'b0;
          end else begin
            tx_ready <= cts_s;
          end
        end
        LOW: begin
          if (cnt_reg == '0) begin
            state_reg <= HIGH;
            link_clk  <= 1'b1;
            cnt_reg   <= RELOAD;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        HIGH: begin
          if (cnt_reg == '0) begin
            // Sample/shift on the last HIGH cycle, just before the falling edge.
            if (op_wr_reg) shift_reg <= {shift_reg[6:0], 1'b0};
            else           rx_shift_reg <= {rx_shift_reg[6:0], din_s};
            link_clk <= 1'b0;
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= IDLE;
              busy      <= 1'b0;
              tx_ready  <= cts_s;
              if (!op_wr_reg) begin
                rx_data  <= {rx_shift_reg[6:0], din_s};
                rx_valid <= 1'b1;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              state_reg   <= LOW;
              cnt_reg     <= RELOAD;
              if (op_wr_reg) link_dout <= shift_reg[6];
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
